// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: counts, sync, active-area coordinates and strobes.
// Optional 16-bit frame counter port enabled by defining VGA_TIMING_FRAME_CNT_EN.
`timescale 1ns/1ps

module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 11
) (
    input  logic          plk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          restart,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic          frame_start,
    output logic [15:0]   frame_cnt
`else
    output logic          frame_start
`endif
);

    localparam int H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int V_BLANK = V_FP + V_SYNC + V_BP;
    localparam int V_TOTAL = V_BLANK + V_ACTIVE;

    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_LO = CW'(H_FP);
    localparam logic [CW-1:0] H_SYNC_HI = CW'(H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] H_VIS_LO  = CW'(H_BLANK);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_SYNC_LO = CW'(V_FP);
    localparam logic [CW-1:0] V_SYNC_HI = CW'(V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] V_VIS_LO  = CW'(V_BLANK);

    logic          h_wrap;
    logic          v_wrap;
    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic          h_vis_nxt;
    logic          v_vis_nxt;
    logic          active_nxt;
    logic          hsync_nxt;
    logic          vsync_nxt;
    logic [CW-1:0] x_nxt;
    logic [CW-1:0] y_nxt;
    logic          line_start_nxt;
    logic          frame_start_nxt;

    // Everything visible is decoded from the next-state counts so that the
    // registered decodes line up with the registered counts.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        h_nxt = h_count;
        v_nxt = v_count;

        h_wrap = ce && (h_count == H_LAST);
        v_wrap = h_wrap && (v_count == V_LAST);

        if (restart) begin
            h_nxt = '0;
            v_nxt = '0;
        end else if (ce) begin
            h_nxt = h_wrap ? '0 : h_count + CW'(1);
            if (h_wrap) begin
                v_nxt = v_wrap ? '0 : v_count + CW'(1);
            end
        end

        h_vis_nxt  = (h_nxt >= H_VIS_LO);
        v_vis_nxt  = (v_nxt >= V_VIS_LO);
        active_nxt = h_vis_nxt && v_vis_nxt;

        hsync_nxt = ((h_nxt >= H_SYNC_LO) && (h_nxt <= H_SYNC_HI)) ? HS_POL : ~HS_POL;
        vsync_nxt = ((v_nxt >= V_SYNC_LO) && (v_nxt <= V_SYNC_HI)) ? VS_POL : ~VS_POL;

        x_nxt = active_nxt ? h_nxt - H_VIS_LO : '0;
        y_nxt = active_nxt ? v_nxt - V_VIS_LO : '0;

        // A restart coinciding with a natural wrap still yields a single strobe.
        line_start_nxt  = restart || h_wrap;
        frame_start_nxt = restart || v_wrap;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge plk or negedge rst_n) begin
        if (!rst_n) begin
            h_count     <= '0;
            v_count     <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            active      <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
            frame_cnt   <= '0;
`endif
        end else begin
            h_count     <= h_nxt;
            v_count     <= v_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            active      <= active_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            line_start  <= line_start_nxt;
            frame_start <= frame_start_nxt;
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (frame_start_nxt) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default VGA, a tiny mode for fast frame wraps, and SVGA.
`timescale 1ns/1ps

module tb_vga_timing_gen;

    logic plk;
    logic rst_n;
    logic ce;
    logic restart;

    // Instance a: default 640x480 timing
    logic [10:0] a_h, a_v, a_x, a_y;
    logic        a_hs, a_vs, a_act, a_ls, a_fs;
    // Instance b: tiny mode, H_TOTAL=15 (blank 7), V_TOTAL=8 (blank 4), positive syncs
    logic [4:0]  b_h, b_v, b_x, b_y;
    logic        b_hs, b_vs, b_act, b_ls, b_fs;
    // Instance c: SVGA 800x600, H_TOTAL=1056, V_TOTAL=628, positive syncs
    logic [10:0] c_h, c_v, c_x, c_y;
    logic        c_hs, c_vs, c_act, c_ls, c_fs;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] a_fc, b_fc, c_fc;
`endif

    vga_timing_gen u_a (
        .plk(plk), .rst_n(rst_n), .ce(ce), .restart(restart),
        .h_count(a_h), .v_count(a_v), .hsync(a_hs), .vsync(a_vs), .active(a_act),
        .x(a_x), .y(a_y), .line_start(a_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_start(a_fs), .frame_cnt(a_fc)
`else
        .frame_start(a_fs)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(5)
    ) u_b (
        .plk(plk), .rst_n(rst_n), .ce(ce), .restart(restart),
        .h_count(b_h), .v_count(b_v), .hsync(b_hs), .vsync(b_vs), .active(b_act),
        .x(b_x), .y(b_y), .line_start(b_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_start(b_fs), .frame_cnt(b_fc)
`else
        .frame_start(b_fs)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(11)
    ) u_c (
        .plk(plk), .rst_n(rst_n), .ce(ce), .restart(restart),
        .h_count(c_h), .v_count(c_v), .hsync(c_hs), .vsync(c_vs), .active(c_act),
        .x(c_x), .y(c_y), .line_start(c_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_start(c_fs), .frame_cnt(c_fc)
`else
        .frame_start(c_fs)
`endif
    );

    initial plk = 1'b0;
    always #5 plk = ~plk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Phase-1 statistics
    int a_hs_first = -1, a_hs_last = -1, a_hs_cnt = 0, a_vs_cnt = 0;
    int a_ls_cnt = 0, a_fs_cnt = 0, a_act_seen = 0;
    int b_fs_cnt = 0, b_fs_bad = 0, b_ls_cnt = 0, b_vs_cnt = 0;
    int c_hs_first = -1, c_hs_last = -1, c_hs_cnt = 0, c_vs_cnt = 0;
    int c_ls_cnt = 0, c_fs_cnt = 0, c_ls_first = 0, c_ls_second = 0;
    // Half-rate / restart statistics
    int prev_h, hold_err, adv_err, ls_k0, ls_k1, ls_n, found, fs_n;

    initial begin
        rst_n   = 1'b0;
        ce      = 1'b1;
        restart = 1'b0;
        repeat (3) @(negedge plk);

        check("rst_a_h",      a_h, 0);
        check("rst_a_v",      a_v, 0);
        check("rst_a_hsync",  a_hs, 1);
        check("rst_a_vsync",  a_vs, 1);
        check("rst_a_active", a_act, 0);
        check("rst_a_x",      a_x, 0);
        check("rst_a_y",      a_y, 0);
        check("rst_a_ls",     a_ls, 0);
        check("rst_a_fs",     a_fs, 0);
        check("rst_b_hsync",  b_hs, 0);
        check("rst_b_vsync",  b_vs, 0);
        check("rst_c_hsync",  c_hs, 0);

        // restart during reset must do nothing
        restart = 1'b1;
        @(negedge plk);
        restart = 1'b0;
        check("rst_restart_ls", a_ls, 0);
        check("rst_restart_fs", a_fs, 0);
        check("rst_restart_h",  a_h, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("rst_b_frame_cnt", b_fc, 0);
`endif

        // ---------------- Phase 1: ce=1 continuous ----------------
        rst_n = 1'b1;
        for (int i = 1; i <= 36500; i++) begin
            @(negedge plk);
            if (i == 1) check("first_ce_h", a_h, 1);

            if (i < 800 && !a_hs) begin
                if (a_hs_first < 0) a_hs_first = int'(a_h);
                a_hs_last = int'(a_h);
                a_hs_cnt++;
            end
            if (!a_vs) a_vs_cnt++;
            if (a_ls) a_ls_cnt++;
            if (a_fs) a_fs_cnt++;
            if (a_act && a_act_seen == 0) begin
                a_act_seen = 1;
                check("act_first_h", a_h, 160);
                check("act_first_v", a_v, 45);
                check("act_first_x", a_x, 0);
                check("act_first_y", a_y, 0);
            end
            if (i == 46*800 + 159) begin
                check("a_pre_vis_active", a_act, 0);
                check("a_pre_vis_x",      a_x, 0);
            end
            if (i == 46*800 + 170) begin
                check("a_vis_x", a_x, 10);
                check("a_vis_y", a_y, 1);
            end

            if (b_fs) begin
                b_fs_cnt++;
                if (b_h != 0 || b_v != 0) b_fs_bad++;
            end
            if (b_ls) b_ls_cnt++;
            if (b_vs) b_vs_cnt++;
            if (i == 119) begin
                check("b_last_h",      b_h, 14);
                check("b_last_v",      b_v, 7);
                check("b_last_active", b_act, 1);
                check("b_last_x",      b_x, 7);
                check("b_last_y",      b_y, 3);
            end
            if (i == 120) begin
                check("b_wrap_active", b_act, 0);
                check("b_wrap_x",      b_x, 0);
                check("b_wrap_y",      b_y, 0);
                check("b_wrap_fs",     b_fs, 1);
            end

            if (i < 1056 && c_hs) begin
                if (c_hs_first < 0) c_hs_first = int'(c_h);
                c_hs_last = int'(c_h);
                c_hs_cnt++;
            end
            if (c_vs) c_vs_cnt++;
            if (c_fs) c_fs_cnt++;
            if (c_ls) begin
                c_ls_cnt++;
                if (c_ls_first == 0) c_ls_first = i;
                else if (c_ls_second == 0) c_ls_second = i;
            end
        end

        check("a_hsync_first", a_hs_first, 16);
        check("a_hsync_last",  a_hs_last, 111);
        check("a_hsync_width", a_hs_cnt, 96);
        check("a_vsync_low",   a_vs_cnt, 1600);
        check("a_active_seen", a_act_seen, 1);
        check("a_line_starts", a_ls_cnt, 45);
        check("a_no_first_fs", a_fs_cnt, 0);
        check("b_frame_starts", b_fs_cnt, 304);
        check("b_fs_not_at_00", b_fs_bad, 0);
        check("b_line_starts",  b_ls_cnt, 2433);
        check("b_vsync_high",   b_vs_cnt, 9126);
        check("c_hsync_first",  c_hs_first, 40);
        check("c_hsync_last",   c_hs_last, 167);
        check("c_hsync_width",  c_hs_cnt, 128);
        check("c_vsync_high",   c_vs_cnt, 4224);
        check("c_line_period",  c_ls_second - c_ls_first, 1056);
        check("c_line_first",   c_ls_first, 1056);
        check("c_line_starts",  c_ls_cnt, 34);
        check("c_no_fs",        c_fs_cnt, 0);

        // ---------------- Asynchronous reset mid-line ----------------
        check("pre_rst_a_h",      a_h, 500);
        check("pre_rst_a_v",      a_v, 45);
        check("pre_rst_a_active", a_act, 1);
        check("pre_rst_a_x",      a_x, 340);
        #2 rst_n = 1'b0;
        #1;
        check("arst_a_h",      a_h, 0);
        check("arst_a_v",      a_v, 0);
        check("arst_a_hsync",  a_hs, 1);
        check("arst_a_active", a_act, 0);
        check("arst_a_x",      a_x, 0);
        check("arst_b_h",      b_h, 0);
        check("arst_c_hsync",  c_hs, 0);
        @(negedge plk);
        rst_n = 1'b1;
        @(negedge plk);
        check("rel_a_h", a_h, 1);
        check("rel_a_v", a_v, 0);

        // ---------------- Phase 2: half-rate ce on instance a ----------------
        prev_h = int'(a_h);
        hold_err = 0; adv_err = 0; ls_k0 = -1; ls_k1 = -1; ls_n = 0;
        for (int k = 0; k < 4000; k++) begin
            ce = (k % 2 == 0);
            @(negedge plk);
            if (!ce) begin
                if (int'(a_h) != prev_h || a_ls || a_fs) hold_err++;
            end else if (int'(a_h) != (prev_h + 1) % 800) begin
                adv_err++;
            end
            if (a_ls) begin
                ls_n++;
                if (ls_k0 < 0) ls_k0 = k;
                else if (ls_k1 < 0) ls_k1 = k;
            end
            prev_h = int'(a_h);
        end
        check("half_hold",      hold_err, 0);
        check("half_advance",   adv_err, 0);
        check("half_ls_first",  ls_k0, 1596);
        check("half_ls_period", ls_k1 - ls_k0, 1600);
        check("half_ls_count",  ls_n, 2);

        // ---------------- Phase 3: restart ----------------
        ce = 1'b1;
        found = 0;
        for (int t = 0; t < 2000 && found == 0; t++) begin
            @(negedge plk);
            if (a_h == 11'd300) found = 1;
        end
        check("wait_a_h300", found, 1);
        restart = 1'b1;
        @(negedge plk);
        restart = 1'b0;
        check("rs_a_h",  a_h, 0);
        check("rs_a_v",  a_v, 0);
        check("rs_a_ls", a_ls, 1);
        check("rs_a_fs", a_fs, 1);
        check("rs_b_fs", b_fs, 1);
        @(negedge plk);
        check("rs_next_a_h",  a_h, 1);
        check("rs_next_a_ls", a_ls, 0);
        check("rs_next_a_fs", a_fs, 0);

        // restart coincident with b's natural (14,7) -> (0,0) wrap
        found = 0;
        for (int t = 0; t < 200 && found == 0; t++) begin
            if (b_h == 5'd14 && b_v == 5'd7) found = 1;
            else @(negedge plk);
        end
        check("wait_b_last", found, 1);
        restart = 1'b1;
        @(negedge plk);
        restart = 1'b0;
        check("coinc_b_h",  b_h, 0);
        check("coinc_b_v",  b_v, 0);
        check("coinc_b_fs", b_fs, 1);
        fs_n = 0;
        for (int t = 0; t < 119; t++) begin
            @(negedge plk);
            if (b_fs) fs_n++;
        end
        check("coinc_single_fs", fs_n, 0);
        @(negedge plk);
        check("coinc_next_frame_fs", b_fs, 1);

        // restart wins even with ce low
        repeat (5) @(negedge plk);
        check("pre_rs_ce0_b_h", b_h, 5);
        ce = 1'b0;
        restart = 1'b1;
        @(negedge plk);
        restart = 1'b0;
        check("rs_ce0_b_h",  b_h, 0);
        check("rs_ce0_b_fs", b_fs, 1);
        @(negedge plk);
        check("ce0_hold_b_h",  b_h, 0);
        check("ce0_hold_b_ls", b_ls, 0);

        // ---------------- Phase 4: three complete frames on b ----------------
        rst_n = 1'b0;
        @(negedge plk);
        rst_n = 1'b1;
        ce = 1'b1;
        fs_n = 0;
        for (int t = 0; t < 360; t++) begin
            @(negedge plk);
            if (b_fs) fs_n++;
        end
        check("b_three_frames_fs", fs_n, 3);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("b_frame_cnt", b_fc, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator; the next generation of the fixed 640x480 horizontal/vertical counter. Generates raw horizontal/vertical counts, polarity-configurable sync outputs, active-video flag, active-area pixel coordinates, and line/frame start strobes for any mode. A clock enable supports pixel rates below the clock rate, and a synchronous restart re-phases the raster. Sits between the pixel-clock domain and the life-grid renderer and VGA pins.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, in pixels
- H_SYNC, 96: horizontal sync width
- H_BP, 48: horizontal back porch
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical porches and sync, in lines
- HS_POL, 0: hsync asserted level (0 = active-low)
- VS_POL, 0: vsync asserted level
- CW, 11: counter and coordinate width; the design must satisfy 2^CW > max(H_TOTAL, V_TOTAL)

Ports:
- plk  in  1  clock; the clock and reset are the only clock and reset
- rst_n  in  1  reset, asynchronous assert, active-low
- ce  in  1  pixel advance enable
- restart  in  1  synchronous raster restart
- h_count  out  CW  horizontal position, 0..H_TOTAL-1
- v_count  out  CW  vertical position, 0..V_TOTAL-1
- hsync, vsync  out  1  sync outputs, polarity set by HS_POL/VS_POL
- active  out  1  high inside the visible area
- x, y  out  CW  visible coordinates; held at 0 outside the visible area
- line_start, frame_start  out  1  single-plk strobes

## Operation
- Derived values: H_BLANK=H_FP+H_SYNC+H_BP and H_TOTAL=H_BLANK+H_ACTIVE. V_BLANK and V_TOTAL are formed the same way.
- Line order: front porch, then sync, then back porch, then visible pixels, with visible pixels last.
  - Horizontal front porch: h_count 0..H_FP-1.
  - Horizontal sync: H_FP..H_FP+H_SYNC-1.
  - Horizontal visible area: H_BLANK..H_TOTAL-1.
  - The vertical axis follows the same order.
- h_count advances only on cycles where ce=1. It wraps from H_TOTAL-1 to 0.
- v_count advances only on a ce cycle where h_count=H_TOTAL-1. It wraps from V_TOTAL-1 to 0.
- restart=1 forces both counts to 0 on the next edge, regardless of ce. restart has priority over ce.
- hsync is at level HS_POL when h_count is in the sync range; otherwise it is at !HS_POL. vsync follows the same rule using v_count and VS_POL.
- vsync is decoded from v_count only, so it changes at the h_count=0 boundary.
- active = (h_count>=H_BLANK) && (v_count>=V_BLANK).
- When active=1: x=h_count-H_BLANK and y=v_count-V_BLANK. Otherwise x=0 and y=0.
- line_start is high for exactly one plk cycle after any edge on which h_count became 0 through a ce wrap or restart.
- frame_start is high for exactly one plk cycle after any edge on which (h_count,v_count) became (0,0) through a wrap or restart.
- If ce is held low, all outputs hold and the strobes stay low.

## Timing
- All outputs are registered.
- hsync, vsync, active, x and y are decoded from next-state counts, so they are cycle-aligned with h_count and v_count. Latency relative to the counts is 0; latency from a ce edge is 1 plk.
- Reset values:
  - h_count=0, v_count=0
  - hsync=!HS_POL, vsync=!VS_POL
  - active=0, x=0, y=0
  - line_start=0, frame_start=0
  - Because the reset state is (0,0), no strobe is produced for the first frame after reset.
- Reset asserted mid-line or mid-frame: all outputs return to their reset values immediately and asynchronously. Counting resumes on the first ce after rst_n deasserts.
- restart arriving at the same edge as a natural wrap produces one strobe, not two.
- restart during reset has no effect.
- Frame period is H_TOTAL*V_TOTAL ce cycles. With defaults this is 800*525=420000.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined:
  - Adds output port frame_cnt, 16 bits, reset 0.
  - It increments on each edge that raises frame_start, including restart-induced ones, and wraps 65535 to 0.
- Macro undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Defaults, ce=1 constant, release reset.
  - hsync is low exactly for h_count 16..111. active first rises at h_count=160, v_count=45, with x=0 and y=0.
  - The last visible pixel is x=639, y=479 at h_count=799, v_count=524.
- Defaults, ce=1 for 420000 cycles after reset.
  - frame_start pulses once, 1 cycle wide, when the counts wrap to (0,0).
  - line_start pulses 525 times. vsync is low for v_count 10..11, which is 1600 ce cycles.
- ce toggling 1,0,1,0 (half rate).
  - Counts advance every 2 plk and the line period is 1600 plk.
  - Strobes stay 1 plk wide and outputs hold during ce=0.
- restart pulsed at h_count=300, v_count=200.
  - The next cycle shows counts at (0,0) and line_start=1, frame_start=1, followed by a normal raster.
  - restart coincident with the wrap from (799,524) gives exactly one frame_start.
- rst_n asserted at h_count=500, v_count=100 with ce=1.
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - After release, h_count=1 follows the first ce.
- Parameters H_ACTIVE=800, H_FP=40, H_SYNC=128, H_BP=88, V_ACTIVE=600, V_FP=1, V_SYNC=4, V_BP=23, HS_POL=1, VS_POL=1 (SVGA).
  - hsync is high for h_count 40..167 and the line period is 1056.
  - With VGA_TIMING_FRAME_CNT_EN defined, frame_cnt reads 3 after 3 complete frames.
